// File: rtl/tq_pkg.sv
// Shared definitions for the tq datapath.
// Holds the default coefficient width, the lane-count default, the transform
// size codes and the helper that turns a size code into an active length.
package tq_pkg;

    localparam int TQ_WIDTH = 28;
    localparam int TQ_MAX_N = 32;

    typedef enum logic [1:0] {
        SZ4  = 2'd0,
        SZ8  = 2'd1,
        SZ16 = 2'd2,
        SZ32 = 2'd3
    } size_e;

    // Active length is 4 << code, never wider than the physical lane count.
    function automatic int size_to_n(input logic [1:0] code, input int max_n);
        int n;
        n = 32'sd4 << code;
        if (n > max_n) begin
            n = max_n;
        end else begin
            n = n;
        end
        return n;
    endfunction

endpackage

// File: rtl/premuat_net.sv
// Combinational butterfly pre-permutation network.
// Ports:
//   enable  - 1 = permute, 0 = identity on all lanes
//   inverse - 1 = de-interleave even/odd, 0 = interleave the two halves
//   size    - transform size code (4/8/16/32 points)
//   in      - packed input lanes, lane k at [k*WIDTH +: WIDTH]
//   out     - packed permuted lanes, same packing
// Lanes at or above the active length always pass straight through.
module premuat_net
    import tq_pkg::*;
#(
    parameter int WIDTH = TQ_WIDTH,
    parameter int MAX_N = TQ_MAX_N
) (
    input  logic                   enable,
    input  logic                   inverse,
    input  logic [1:0]             size,
    input  logic [MAX_N*WIDTH-1:0] in,
    output logic [MAX_N*WIDTH-1:0] out
);

    // Per output lane, pick the source lane for the current size and mode.
    always_comb begin
        int n_s;
        int h_s;
        int src_s;
        out   = in;
        n_s   = size_to_n(size, MAX_N);
        h_s   = n_s / 32'sd2;
        src_s = 32'sd0;
        for (int j = 0; j < MAX_N; j++) begin
            if (enable && (j < n_s)) begin
                if (inverse) begin
                    // First half takes the even lanes, second half the odd ones.
                    if (j < h_s) begin
                        src_s = 32'sd2 * j;
                    end else begin
                        src_s = 32'sd2 * (j - h_s) + 32'sd1;
                    end
                end else begin
                    // Even outputs from the low half, odd outputs from the high half.
                    if ((j % 32'sd2) == 32'sd0) begin
                        src_s = j / 32'sd2;
                    end else begin
                        src_s = j / 32'sd2 + h_s;
                    end
                end
            end else begin
                src_s = j;
            end
            out[j*WIDTH +: WIDTH] = in[src_s*WIDTH +: WIDTH];
        end
    end

endmodule

// File: rtl/premuat_pipe.sv
// Registered pre-permutation stage between transpose memory and butterfly.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   i_valid / i_ready   - input handshake (i_ready = !o_valid || o_ready)
//   i_enable, i_inverse - permute enable and direction, sampled on transfer
//   i_size              - transform size code, sampled on transfer
//   i_data              - packed input lanes
//   o_valid / o_ready   - output handshake
//   o_data              - permuted vector
//   o_size, o_inverse   - size and direction captured with the vector
// One cycle of latency, one vector per cycle while downstream is ready.
module premuat_pipe
    import tq_pkg::*;
#(
    parameter int WIDTH = TQ_WIDTH,
    parameter int MAX_N = TQ_MAX_N
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_valid,
    output logic                   i_ready,
    input  logic                   i_enable,
    input  logic                   i_inverse,
    input  logic [1:0]             i_size,
    input  logic [MAX_N*WIDTH-1:0] i_data,
    output logic                   o_valid,
    input  logic                   o_ready,
    output logic [MAX_N*WIDTH-1:0] o_data,
    output logic [1:0]             o_size,
    output logic                   o_inverse
);

    logic [MAX_N*WIDTH-1:0] perm_s;
    logic [MAX_N*WIDTH-1:0] data_r;
    logic [1:0]             size_r;
    logic                   inverse_r;
    logic                   valid_r;
    logic                   take_s;

    premuat_net #(
        .WIDTH (WIDTH),
        .MAX_N (MAX_N)
    ) u_net (
        .enable  (i_enable),
        .inverse (i_inverse),
        .size    (i_size),
        .in      (i_data),
        .out     (perm_s)
    );

    // The register can load whenever it is empty or being drained this cycle.
    assign i_ready = !valid_r || o_ready;
    assign take_s  = i_valid && i_ready;

    // Output register: load on input transfer, drop valid on drain, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r   <= 1'b0;
            data_r    <= '0;
            size_r    <= 2'd0;
            inverse_r <= 1'b0;
        end else if (take_s) begin
            valid_r   <= 1'b1;
            data_r    <= perm_s;
            size_r    <= i_size;
            inverse_r <= i_inverse;
        end else if (o_ready) begin
            valid_r   <= 1'b0;
        end else begin
            valid_r   <= valid_r;
        end
    end

    assign o_valid   = valid_r;
    assign o_data    = data_r;
    assign o_size    = size_r;
    assign o_inverse = inverse_r;

endmodule

// File: tb/tb_premuat_pipe.sv
module tb_premuat_pipe;

    localparam int W = 28;
    localparam int M = 32;

    typedef logic [M*W-1:0] vec_t;
    typedef struct {
        vec_t       data;
        logic [1:0] size;
        logic       inv;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_valid = 1'b0;
    logic       i_ready;
    logic       i_enable = 1'b0;
    logic       i_inverse = 1'b0;
    logic [1:0] i_size = 2'd0;
    vec_t       i_data = '0;
    logic       o_valid;
    logic       o_ready = 1'b0;
    vec_t       o_data;
    logic [1:0] o_size;
    logic       o_inverse;

    int   total = 0;
    int   bad = 0;
    exp_t sb[$];
    logic exp_valid;

    premuat_pipe #(.WIDTH(W), .MAX_N(M)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_valid   (i_valid),
        .i_ready   (i_ready),
        .i_enable  (i_enable),
        .i_inverse (i_inverse),
        .i_size    (i_size),
        .i_data    (i_data),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .o_data    (o_data),
        .o_size    (o_size),
        .o_inverse (o_inverse)
    );

    always #5 clk = ~clk;

    // Reference permutation written straight from the index rules.
    function automatic vec_t model(input logic en, input logic inv, input logic [1:0] sz, input vec_t din);
        logic [W-1:0] a[M];
        logic [W-1:0] b[M];
        vec_t r;
        int n, h;
        n = 4 << sz;
        if (n > M) n = M;
        h = n / 2;
        for (int k = 0; k < M; k++) begin
            a[k] = din[k*W +: W];
            b[k] = a[k];
        end
        if (en) begin
            for (int k = 0; k < h; k++) begin
                if (!inv) begin
                    b[2*k]   = a[k];
                    b[2*k+1] = a[k+h];
                end else begin
                    b[k]   = a[2*k];
                    b[k+h] = a[2*k+1];
                end
            end
        end
        for (int k = 0; k < M; k++) r[k*W +: W] = b[k];
        return r;
    endfunction

    function automatic vec_t rand_vec();
        vec_t r;
        for (int k = 0; k < M; k++) r[k*W +: W] = W'($urandom);
        return r;
    endfunction

    task automatic check_vec(input string name, input vec_t got, input vec_t want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Model of output occupancy, driven only by bench stimulus.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) exp_valid <= 1'b0;
        else if (i_valid && (!exp_valid || o_ready)) exp_valid <= 1'b1;
        else if (o_ready) exp_valid <= 1'b0;
    end

    // Stimulus side: record expected result of every accepted vector.
    always @(negedge clk) begin
        if (rst_n && i_valid && (!exp_valid || o_ready)) begin
            exp_t e;
            e.data = model(i_enable, i_inverse, i_size, i_data);
            e.size = i_size;
            e.inv  = i_inverse;
            sb.push_back(e);
        end
    end

    // Monitor: handshake check every cycle, data check whenever output is valid.
    always @(negedge clk) begin
        if (rst_n) begin
            check_bit("o_valid", o_valid, exp_valid);
            check_bit("i_ready", i_ready, !exp_valid || o_ready);
            if (o_valid) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output: got vector %h want none", o_data);
                end else begin
                    check_vec("sb_data", o_data, sb[0].data);
                    total++;
                    if (o_size !== sb[0].size || o_inverse !== sb[0].inv) begin
                        bad++;
                        $display("FAIL sb_tag: got size=%0d inv=%b want size=%0d inv=%b",
                                 o_size, o_inverse, sb[0].size, sb[0].inv);
                    end
                    if (o_ready) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic step(input logic v, input logic en, input logic inv, input logic [1:0] sz,
                        input vec_t d, input logic rdy);
        @(posedge clk);
        #1;
        i_valid   = v;
        i_enable  = en;
        i_inverse = inv;
        i_size    = sz;
        i_data    = d;
        o_ready   = rdy;
    endtask

    task automatic send_and_check(input string name, input logic en, input logic inv,
                                  input logic [1:0] sz, input vec_t d, input vec_t want);
        step(1'b1, en, inv, sz, d, 1'b1);
        step(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
        @(negedge clk);
        check_vec(name, o_data, want);
    endtask

    initial begin
        vec_t ramp, neg, fwd32, c100, want, va, vb, vc;
        int fwd8[8] = '{0, 4, 1, 5, 2, 6, 3, 7};
        int inv8[8] = '{0, 2, 4, 6, 1, 3, 5, 7};
        int fwd4[4] = '{0, 2, 1, 3};

        for (int k = 0; k < M; k++) begin
            ramp[k*W +: W] = W'(k);
            neg[k*W +: W]  = W'(-k);
            c100[k*W +: W] = W'(100 + k);
        end

        // Reset state
        #2;
        check_bit("rst_o_valid", o_valid, 1'b0);
        check_vec("rst_o_data", o_data, '0);
        check_bit("rst_o_inverse", o_inverse, 1'b0);
        total++;
        if (o_size !== 2'd0) begin
            bad++;
            $display("FAIL rst_o_size: got %0d want 0", o_size);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // 8-point forward and inverse, 4-point forward, against fixed tables
        want = ramp;
        for (int k = 0; k < 8; k++) want[k*W +: W] = W'(fwd8[k]);
        send_and_check("fwd8", 1'b1, 1'b0, 2'd1, ramp, want);
        want = ramp;
        for (int k = 0; k < 8; k++) want[k*W +: W] = W'(inv8[k]);
        send_and_check("inv8", 1'b1, 1'b1, 2'd1, ramp, want);
        want = ramp;
        for (int k = 0; k < 4; k++) want[k*W +: W] = W'(fwd4[k]);
        send_and_check("fwd4", 1'b1, 1'b0, 2'd0, ramp, want);

        // 32-point forward on negative lanes, then the inverse round trip
        for (int k = 0; k < 16; k++) begin
            fwd32[(2*k)*W +: W]   = W'(-k);
            fwd32[(2*k+1)*W +: W] = W'(-(k + 16));
        end
        send_and_check("fwd32_neg", 1'b1, 1'b0, 2'd3, neg, fwd32);
        send_and_check("roundtrip32", 1'b1, 1'b1, 2'd3, fwd32, neg);

        // Identity when disabled, every size and mode
        for (int s = 0; s < 4; s++) begin
            for (int m = 0; m < 2; m++) begin
                send_and_check("bypass", 1'b0, m[0], s[1:0], c100, c100);
            end
        end

        // A then stall 3 cycles while B waits, then B and C
        va = rand_vec(); vb = rand_vec(); vc = rand_vec();
        step(1'b1, 1'b1, 1'b0, 2'd2, va, 1'b1);
        step(1'b1, 1'b1, 1'b1, 2'd2, vb, 1'b0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_bit("stall_i_ready", i_ready, 1'b0);
            check_vec("stall_hold_a", o_data, model(1'b1, 1'b0, 2'd2, va));
            if (c < 2) step(1'b1, 1'b1, 1'b1, 2'd2, vb, 1'b0);
        end
        step(1'b1, 1'b1, 1'b1, 2'd2, vb, 1'b1);
        step(1'b1, 1'b0, 1'b0, 2'd3, vc, 1'b1);
        @(negedge clk);
        check_vec("b_after_stall", o_data, model(1'b1, 1'b1, 2'd2, vb));
        step(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
        @(negedge clk);
        check_vec("c_after_b", o_data, vc);
        step(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);

        // Asynchronous reset in the middle of a stall
        step(1'b1, 1'b1, 1'b0, 2'd1, va, 1'b1);
        step(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_bit("async_rst_valid", o_valid, 1'b0);
        check_vec("async_rst_data", o_data, '0);
        sb.delete();
        @(posedge clk);
        #3;
        rst_n   = 1'b1;
        o_ready = 1'b1;
        @(negedge clk);
        check_bit("post_rst_i_ready", i_ready, 1'b1);
        check_bit("post_rst_o_valid", o_valid, 1'b0);
        send_and_check("post_rst_vec", 1'b1, 1'b1, 2'd1, ramp, model(1'b1, 1'b1, 2'd1, ramp));

        // Random traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0), 1'($urandom),
                 2'($urandom), rand_vec(), 1'($urandom_range(0, 9) < 7));
        end
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b0, 2'd0, '0, 1'b1);
        @(negedge clk);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/premuat_pipe.md
Name: premuat_pipe

Overview:
- Parametrised, registered successor to the fixed 8-point butterfly pre-permutation in the tq datapath.
- Reorders one vector of coefficients per transfer for 4/8/16/32-point DCT/IDCT stages.
- Forward mode interleaves the two halves; inverse mode de-interleaves even/odd indices.
- Sits between transpose memory and butterfly stage; valid/ready handshake with one-cycle latency and full-throughput backpressure.

Parameters:
- WIDTH, 28, coefficient width in bits, signed.
- MAX_N, 32, physical lane count; legal values 4, 8, 16, 32.

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- i_valid  input  1  input vector valid.
- i_ready  output  1  block can accept input this cycle.
- i_enable  input  1  1 = permute, 0 = identity pass-through.
- i_inverse  input  1  1 = inverse (de-interleave), 0 = forward (interleave).
- i_size  input  2  0 = 4-pt, 1 = 8-pt, 2 = 16-pt, 3 = 32-pt.
- i_data  input  MAX_N*WIDTH  lane k is at bits [k*WIDTH +: WIDTH].
- o_valid  output  1  output vector valid.
- o_ready  input  1  downstream accepts.
- o_data  output  MAX_N*WIDTH  permuted vector, same lane packing.
- o_size  output  2  i_size captured with the vector.
- o_inverse  output  1  i_inverse captured with the vector.

Behaviour:
- Clocking and reset: single clock domain. Reset asynchronous, active-low: rst_n low clears o_valid, o_data, o_size and o_inverse to 0 immediately.
- Active length: N = 4 << i_size. If N > MAX_N, N is clamped to MAX_N. H = N/2.
- Forward permutation (enable=1, inverse=0), for k < H: out[2k] = in[k], out[2k+1] = in[k+H].
- Inverse permutation (enable=1, inverse=1), for k < H: out[k] = in[2k], out[k+H] = in[2k+1].
- Both mappings fix lanes 0 and N-1. For N=8 they match the legacy 8-point block exactly.
- Lanes N..MAX_N-1 always pass through unchanged.
- enable=0: out = in on all lanes.
- Values are copied bit-exact; no arithmetic, sign extension or saturation.
- Handshake:
  - i_ready = !o_valid || o_ready (combinational).
  - A transfer in is i_valid && i_ready. A transfer out is o_valid && o_ready.
- Output register, updated on posedge clk:
  - Transfer in: o_data <= permuted vector, o_size/o_inverse <= inputs, o_valid <= 1.
  - Else if o_ready: o_valid <= 0, and o_data holds its last value.
  - Else (stall): all outputs hold.
- Latency: exactly 1 cycle from accepted input to o_valid.
- Throughput: 1 vector/cycle while o_ready = 1.
- Simultaneous output and input transfer in the same cycle: the new vector replaces the old; o_valid stays 1.
- While stalled (o_valid=1, o_ready=0): i_ready=0. Changes on i_enable/i_inverse/i_size/i_data have no effect.
- Mode and size are sampled only at input transfer. Changing them between vectors needs no flush.
- Reset mid-stream discards the held vector. First post-reset cycle: i_ready=1, o_valid=0.
- No internal state beyond the single output register stage.

Decomposition:
- Package tq_pkg:
  - WIDTH default.
  - Size codes SZ4=0, SZ8=1, SZ16=2, SZ32=3.
  - Function size_to_n (4 << code, clamped to MAX_N).
- Sub-module premuat_net: purely combinational permutation network.
  - Parameters WIDTH, MAX_N.
  - Ports enable, inverse, size, in, out.
  - Implemented as a per-lane mux indexed by size and mode.
- premuat_pipe wraps premuat_net with the handshake and output register.

Test Plan:
- MAX_N=32, size=1, forward, lane k = k, o_ready=1: o_data lanes 0..7 = 0,4,1,5,2,6,3,7; lanes 8..31 = 8..31; o_valid one cycle after i_valid.
- Same vector, inverse, size=1: lanes 0..7 = 0,2,4,6,1,3,5,7; size=0 forward: lanes 0..3 = 0,2,1,3, rest identity.
- size=3, forward, lane k = -k (signed, 28-bit): out[2k] = -k and out[2k+1] = -(k+16) for k<16; negative values bit-exact. Forward followed by inverse round-trips to the original vector.
- enable=0 with any size/mode, lane k = 100+k: output equals input on all lanes.
- Back-to-back vectors A,B,C with o_ready low for 3 cycles after A is output: A holds stable, i_ready=0 during stall, B then C emerge in order with no loss or duplication.
- rst_n pulled low asynchronously mid-stall with o_valid=1: o_valid and o_data go to 0 before the next clk edge; after release, i_ready=1 and the next vector appears with 1-cycle latency.
